// File: rtl/grid_pkg.sv
// Shared geometry defaults and drawing-mode encodings for the playfield grid overlay.
package grid_pkg;

    localparam int DEF_X0   = 104;
    localparam int DEF_Y0   = 17;
    localparam int DEF_CELL = 26;
    localparam int DEF_COLS = 14;
    localparam int DEF_ROWS = 22;

    typedef enum logic [1:0] {
        GRID_OFF    = 2'd0,
        GRID_DOTS   = 2'd1,
        GRID_LINES  = 2'd2,
        GRID_BORDER = 2'd3
    } grid_mode_e;

endpackage

// File: rtl/grid_axis_tracker.sv
// Incremental position tracker for one raster axis: reports whether the axis is inside
// the grid span, which cell it is in and the offset inside that cell. The registered
// state always describes the position sampled at the same edge; a sample that does not
// continue the tracked sequence raises a one-cycle err and drops tracking until the
// next origin crossing.
module grid_axis_tracker
    import grid_pkg::*;
#(
    parameter int ORIGIN = DEF_X0,
    parameter int CELL   = DEF_CELL,
    parameter int COUNT  = DEF_COLS,
    parameter int POS_W  = 11,
    localparam int IDX_W = $clog2(COUNT + 1),
    localparam int SUB_W = $clog2(CELL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] pos,
    input  logic             advance,
    output logic             act,
    output logic [IDX_W-1:0] idx,
    output logic [SUB_W-1:0] sub,
    output logic             err
);

    localparam logic [31:0]      LO       = 32'(ORIGIN);
    localparam logic [31:0]      HI       = 32'(ORIGIN + COUNT * CELL);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(COUNT);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL - 1);

    logic [31:0]      w_pos32;
    logic             w_at_origin;
    logic             w_in_range;
    logic             w_act_n;
    logic [IDX_W-1:0] w_idx_n;
    logic [SUB_W-1:0] w_sub_n;
    logic             w_err_n;
    logic [31:0]      w_expect;

    assign w_pos32     = 32'(pos);
    assign w_at_origin = (w_pos32 == LO);
    assign w_in_range  = (w_pos32 >= LO) && (w_pos32 <= HI);

    // Next tracker state: origin resync, span exit, end-of-grid, or step with consistency check.
    always_comb begin
        w_act_n  = act;
        w_idx_n  = idx;
        w_sub_n  = sub;
        w_err_n  = 1'b0;
        w_expect = '0;
        if (advance) begin
            if (w_at_origin) begin
                w_act_n = 1'b1;
                w_idx_n = '0;
                w_sub_n = '0;
            end else if (!w_in_range || !act || (idx == IDX_LAST && sub == '0)) begin
                w_act_n = 1'b0;
                w_idx_n = '0;
                w_sub_n = '0;
            end else begin
                if (sub == SUB_LAST) begin
                    w_sub_n = '0;
                    w_idx_n = idx + IDX_W'(1);
                end else begin
                    w_sub_n = sub + SUB_W'(1);
                end
                // The stepped state must describe the raster value actually sampled.
                w_expect = LO + 32'(w_idx_n) * 32'(CELL) + 32'(w_sub_n);
                if (w_expect != w_pos32) begin
                    w_err_n = 1'b1;
                    w_act_n = 1'b0;
                    w_idx_n = '0;
                    w_sub_n = '0;
                end
            end
        end
    end

    // Tracker state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act <= 1'b0;
            idx <= '0;
            sub <= '0;
            err <= 1'b0;
        end else begin
            act <= w_act_n;
            idx <= w_idx_n;
            sub <= w_sub_n;
            err <= w_err_n;
        end
    end

endmodule

// File: rtl/grid_overlay.sv
// Playfield grid overlay: tracks the raster with one tracker per axis (stage 1), then
// forms the overlay pixel and the cell coordinates in an output register (stage 2).
module grid_overlay
    import grid_pkg::*;
#(
    parameter int         X0         = DEF_X0,
    parameter int         Y0         = DEF_Y0,
    parameter int         CELL       = DEF_CELL,
    parameter int         COLS       = DEF_COLS,
    parameter int         ROWS       = DEF_ROWS,
    parameter logic [7:0] GRID_COLOR = 8'hFF
) (
    input  logic                          vclk,
    input  logic                          rst_n,
    input  logic [10:0]                   hcount,
    input  logic [9:0]                    vcount,
    input  logic [1:0]                    grid_mode,
    output logic [7:0]                    pixel_grid,
    output logic                          in_field,
    output logic [$clog2(COLS + 1)-1:0]   cell_col,
    output logic [$clog2(ROWS + 1)-1:0]   cell_row,
    output logic [$clog2(CELL)-1:0]       cell_x,
    output logic [$clog2(CELL)-1:0]       cell_y,
    output logic                          trk_err
);

    localparam int COL_W = $clog2(COLS + 1);
    localparam int ROW_W = $clog2(ROWS + 1);
    localparam int SUB_W = $clog2(CELL);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS);

    logic [9:0]       r_vcount_prev;
    grid_mode_e       r_mode;
    logic             r_fs_p1;
    logic             w_frame_start;
    logic             w_v_adv;

    logic             w_h_act;
    logic [COL_W-1:0] w_h_idx;
    logic [SUB_W-1:0] w_h_sub;
    logic             w_h_err;
    logic             w_v_act;
    logic [ROW_W-1:0] w_v_idx;
    logic [SUB_W-1:0] w_v_sub;
    logic             w_v_err;

    logic             w_on_h;
    logic             w_on_v;
    logic             w_h_edge;
    logic             w_v_edge;
    logic             w_in_field;
    logic             w_pix_on;

    assign w_frame_start = (hcount == '0) && (vcount == '0);
    assign w_v_adv       = (vcount != r_vcount_prev);

    grid_axis_tracker #(
        .ORIGIN (X0),
        .CELL   (CELL),
        .COUNT  (COLS),
        .POS_W  (11)
    ) u_h_trk (
        .clk     (vclk),
        .rst_n   (rst_n),
        .pos     (hcount),
        .advance (1'b1),
        .act     (w_h_act),
        .idx     (w_h_idx),
        .sub     (w_h_sub),
        .err     (w_h_err)
    );

    grid_axis_tracker #(
        .ORIGIN (Y0),
        .CELL   (CELL),
        .COUNT  (ROWS),
        .POS_W  (10)
    ) u_v_trk (
        .clk     (vclk),
        .rst_n   (rst_n),
        .pos     (vcount),
        .advance (w_v_adv),
        .act     (w_v_act),
        .idx     (w_v_idx),
        .sub     (w_v_sub),
        .err     (w_v_err)
    );

    // Stage 1 control: line-change detect, frame-start flag and mode latched once per frame.
    always_ff @(posedge vclk or negedge rst_n) begin
        if (!rst_n) begin
            r_vcount_prev <= '0;
            r_mode        <= GRID_OFF;
            r_fs_p1       <= 1'b0;
        end else begin
            r_vcount_prev <= vcount;
            r_fs_p1       <= w_frame_start;
            if (w_frame_start) begin
                r_mode <= grid_mode_e'(grid_mode);
            end
        end
    end

    // Pixel decision from the tracker state; the border mode keeps only the outermost lines.
    always_comb begin
        w_on_h     = w_h_act && (w_h_sub == '0);
        w_on_v     = w_v_act && (w_v_sub == '0);
        w_h_edge   = (w_h_idx == '0) || (w_h_idx == COL_LAST);
        w_v_edge   = (w_v_idx == '0) || (w_v_idx == ROW_LAST);
        w_in_field = w_h_act && w_v_act;
        w_pix_on   = 1'b0;
        case (r_mode)
            GRID_DOTS:   w_pix_on = w_on_h && w_on_v;
            GRID_LINES:  w_pix_on = (w_on_h && w_v_act) || (w_on_v && w_h_act);
            GRID_BORDER: w_pix_on = (w_on_h && w_v_act && w_h_edge) ||
                                    (w_on_v && w_h_act && w_v_edge);
            default:     w_pix_on = 1'b0;
        endcase
    end

    // Stage 2 output register; the desync flag is sticky until the next frame start.
    always_ff @(posedge vclk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_grid <= '0;
            in_field   <= 1'b0;
            cell_col   <= '0;
            cell_row   <= '0;
            cell_x     <= '0;
            cell_y     <= '0;
            trk_err    <= 1'b0;
        end else begin
            pixel_grid <= w_pix_on ? GRID_COLOR : 8'h00;
            in_field   <= w_in_field;
            cell_col   <= w_in_field ? w_h_idx : '0;
            cell_row   <= w_in_field ? w_v_idx : '0;
            cell_x     <= w_in_field ? w_h_sub : '0;
            cell_y     <= w_in_field ? w_v_sub : '0;
            trk_err    <= r_fs_p1 ? 1'b0 : (trk_err | w_h_err | w_v_err);
        end
    end

endmodule

// File: tb/tb_grid_overlay.sv
// Scoreboard bench for grid_overlay with default geometry (X0=104, Y0=17, CELL=26,
// COLS=14, ROWS=22). Each driven raster sample pushes its expected response; a monitor
// pops one entry per cycle once the two-stage pipeline is filled.
module tb_grid_overlay;

    logic        vclk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [1:0]  grid_mode;
    logic [7:0]  pixel_grid;
    logic        in_field;
    logic [3:0]  cell_col;
    logic [4:0]  cell_row;
    logic [4:0]  cell_x;
    logic [4:0]  cell_y;
    logic        trk_err;

    grid_overlay dut (
        .vclk       (vclk),
        .rst_n      (rst_n),
        .hcount     (hcount),
        .vcount     (vcount),
        .grid_mode  (grid_mode),
        .pixel_grid (pixel_grid),
        .in_field   (in_field),
        .cell_col   (cell_col),
        .cell_row   (cell_row),
        .cell_x     (cell_x),
        .cell_y     (cell_y),
        .trk_err    (trk_err)
    );

    always #5 vclk = ~vclk;

    typedef struct {
        int h;
        int v;
        int pix;
        int inf;
        int col;
        int row;
        int x;
        int y;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   hits     = 0;
    bit   mon_en   = 1'b0;

    // reference state: latched mode, trackers knocked out, sticky error
    int   lmode   = 0;
    bit   hdead   = 1'b0;
    bit   vdead   = 1'b0;
    bit   errflag = 1'b0;

    task automatic check(input string name, input int h, input int v, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s h=%0d v=%0d actual=%0d required=%0d", name, h, v, act, req);
        end
    endtask

    // Expected outputs computed directly from the absolute raster position.
    function automatic exp_t model(input int h, input int v);
        exp_t e;
        bit ha, va, onh, onv, pix;
        int hi, hs, vi, vs;
        ha  = !hdead && (h >= 104) && (h <= 468);
        va  = !vdead && (v >= 17) && (v <= 589);
        hi  = (h - 104) / 26;
        hs  = (h - 104) % 26;
        vi  = (v - 17) / 26;
        vs  = (v - 17) % 26;
        onh = ha && (hs == 0);
        onv = va && (vs == 0);
        case (lmode)
            1: pix = onh && onv;
            2: pix = (onh && va) || (onv && ha);
            3: pix = (onh && va && (hi == 0 || hi == 14)) || (onv && ha && (vi == 0 || vi == 22));
            default: pix = 1'b0;
        endcase
        e.h   = h;
        e.v   = v;
        e.pix = pix ? 255 : 0;
        e.inf = (ha && va) ? 1 : 0;
        e.col = (ha && va) ? hi : 0;
        e.row = (ha && va) ? vi : 0;
        e.x   = (ha && va) ? hs : 0;
        e.y   = (ha && va) ? vs : 0;
        e.err = errflag ? 1 : 0;
        return e;
    endfunction

    task automatic drive_now(input int h, input int v);
        hcount = 11'(h);
        vcount = 10'(v);
        if (h == 0 && v == 0) begin
            lmode   = int'(grid_mode);
            errflag = 1'b0;
            vdead   = 1'b0;
        end
        exp_q.push_back(model(h, v));
    endtask

    task automatic drive(input int h, input int v);
        @(negedge vclk);
        drive_now(h, v);
    endtask

    function automatic bit full_line(input int v);
        return ((v >= 17) && (v <= 589) && ((v - 17) % 26 == 0)) || (v == 30) || (v == 70) || (v == 300);
    endfunction

    task automatic drive_line(input int v, input bit desync);
        int lo, hi;
        hdead = 1'b0;
        if (v == 0) begin
            lo = 0;
            hi = 3;
        end else if (full_line(v)) begin
            lo = 100;
            hi = 472;
        end else begin
            lo = 102;
            hi = 106;
        end
        if (desync && v == 60) begin
            for (int h = 100; h <= 200; h++) drive(h, v);
            hdead   = 1'b1;
            errflag = 1'b1;
            for (int h = 300; h <= 472; h++) drive(h, v);
        end else begin
            for (int h = lo; h <= hi; h++) drive(h, v);
        end
    endtask

    // Line 300 with an asynchronous reset pulse at hcount=150.
    task automatic reset_line();
        hdead = 1'b0;
        for (int h = 100; h <= 150; h++) drive(h, 300);
        @(posedge vclk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pix",   150, 300, int'(pixel_grid), 0);
        check("rst_inf",   150, 300, int'(in_field), 0);
        check("rst_col",   150, 300, int'(cell_col), 0);
        check("rst_row",   150, 300, int'(cell_row), 0);
        check("rst_x",     150, 300, int'(cell_x), 0);
        check("rst_y",     150, 300, int'(cell_y), 0);
        check("rst_err",   150, 300, int'(trk_err), 0);
        mon_en = 1'b0;
        @(negedge vclk);
        @(negedge vclk);
        rst_n = 1'b1;
        exp_q.delete();
        lmode   = 0;
        vdead   = 1'b1;
        hdead   = 1'b1;
        errflag = 1'b0;
        mon_en  = 1'b1;
        drive_now(151, 300);
        for (int h = 152; h <= 472; h++) drive(h, 300);
    endtask

    task automatic drive_frame(input int mode, input int last_v, input bit switch200,
                               input bit desync, input bit do_rst);
        grid_mode = 2'(mode);
        hits = 0;
        for (int v = 0; v <= last_v; v++) begin
            if (switch200 && v == 200) grid_mode = 2'd2;
            if (do_rst && v == 300) reset_line();
            else drive_line(v, desync);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, sampled 1 time unit after the clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge vclk);
            #1;
            if (mon_en && exp_q.size() >= 2) begin
                e = exp_q.pop_front();
                if (pixel_grid == 8'hFF) hits++;
                check("pixel_grid", e.h, e.v, int'(pixel_grid), e.pix);
                check("in_field",   e.h, e.v, int'(in_field),   e.inf);
                check("cell_col",   e.h, e.v, int'(cell_col),   e.col);
                check("cell_row",   e.h, e.v, int'(cell_row),   e.row);
                check("cell_x",     e.h, e.v, int'(cell_x),     e.x);
                check("cell_y",     e.h, e.v, int'(cell_y),     e.y);
                check("trk_err",    e.h, e.v, int'(trk_err),    e.err);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        hcount    = '0;
        vcount    = '0;
        grid_mode = 2'd0;
        repeat (3) @(negedge vclk);
        check("reset_pix", 0, 0, int'(pixel_grid), 0);
        check("reset_inf", 0, 0, int'(in_field), 0);
        check("reset_col", 0, 0, int'(cell_col), 0);
        check("reset_row", 0, 0, int'(cell_row), 0);
        check("reset_x",   0, 0, int'(cell_x), 0);
        check("reset_y",   0, 0, int'(cell_y), 0);
        check("reset_err", 0, 0, int'(trk_err), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // mode off, partial frame: trackers run, nothing drawn
        drive_frame(0, 45, 1'b0, 1'b0, 1'b0);
        // dots, full frame
        drive_frame(1, 591, 1'b0, 1'b0, 1'b0);
        check("dot_hits_f1", 0, 591, hits, 345);
        // dots latched, grid_mode switched to lines mid-frame
        drive_frame(1, 591, 1'b1, 1'b0, 1'b0);
        check("dot_hits_f2", 0, 591, hits, 345);
        // lines, with an hcount jump on line 60
        drive_frame(2, 591, 1'b0, 1'b1, 1'b0);
        // border, jump on line 60, reset pulse on line 300
        drive_frame(3, 591, 1'b0, 1'b1, 1'b1);
        // lines again after reset: reacquire from the frame start
        drive_frame(2, 45, 1'b0, 1'b0, 1'b0);
        drive(10, 46);
        drive(11, 46);
        @(posedge vclk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grid_overlay.md
Name: grid_overlay

Overview:
- Parametrised successor to the fixed playfield grid generator. It draws the Tetris playfield grid over the VGA raster.
- Origin, cell pitch, column and row counts, and colour are set by parameters. Four drawing modes are provided.
- Per-axis counters track raster position incrementally. The block outputs the current cell column/row and intra-cell offset for downstream board-memory lookup.
- Sits between the VGA timing generator (hcount/vcount) and the pixel mux.

Parameters:
- X0, 104, hcount of leftmost vertical grid line
- Y0, 17, vcount of topmost horizontal grid line
- CELL, 26, cell pitch in pixels (both axes), >=2
- COLS, 14, number of cell columns; vertical lines at X0+k*CELL, k=0..COLS
- ROWS, 22, number of cell rows; horizontal lines at Y0+k*CELL, k=0..ROWS
- GRID_COLOR, 8'hFF, pixel value driven on grid pixels

Ports:
- vclk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hcount  in  11  raster column; +1 per vclk within a line
- vcount  in  10  raster line
- grid_mode  in  2  0 off, 1 dots, 2 lines, 3 border
- pixel_grid  out  8  overlay pixel; 0 = transparent
- in_field  out  1  pixel lies inside the grid rectangle, lines included
- cell_col  out  clog2(COLS+1)  column index 0..COLS
- cell_row  out  clog2(ROWS+1)  row index 0..ROWS
- cell_x  out  clog2(CELL)  offset within cell, 0 = on the line
- cell_y  out  clog2(CELL)  offset within cell
- trk_err  out  1  sticky tracker desync flag

Behaviour:
- Reset values:
  - All outputs 0.
  - Latched mode = 0.
  - Both trackers inactive.
- Latency:
  - Stage 1: trackers register the position of the hcount/vcount sampled at that edge.
  - Stage 2: output register.
  - All outputs correspond to the hcount/vcount sampled 2 vclk earlier.
- H tracker (state: act, idx, sub):
  - Advances every cycle.
  - hcount==X0: act=1, idx=0, sub=0.
  - Else if act: if sub==CELL-1, then sub=0, idx++; otherwise sub++.
  - When idx==COLS and sub==0, the next advance sets act=0 (grid ends after its last line pixel).
  - hcount outside [X0, X0+COLS*CELL]: act=0.
- V tracker: same rules with Y0/ROWS. It advances only when vcount differs from the previous cycle's vcount (registered copy).
- Desync:
  - Condition: tracker act=1 and the raster value != origin + idx*CELL + sub.
  - Response: set trk_err and force that tracker inactive. It reacquires at the next origin crossing.
  - trk_err clears at frame start (hcount==0 and vcount==0).
- on_h = h.act && h.sub==0; on_v = v.act && v.sub==0.
- Mode:
  - grid_mode is latched only at frame start, so there is no mid-frame tearing.
  - Latched mode 0: pixel_grid = 0.
  - Latched mode 1 (dots): GRID_COLOR when on_h && on_v.
  - Latched mode 2 (lines): GRID_COLOR when (on_h && v.act) || (on_v && h.act).
  - Latched mode 3 (border): as mode 2, restricted to idx==0 or idx==last on the line axis.
  - Otherwise pixel_grid = 0. It never holds a stale value.
- in_field = h.act && v.act. cell_col/row/x/y are the tracker idx/sub, and are 0 when in_field=0.
- Reset asserted mid-frame: immediate clear of all outputs. Trackers resume at the next origin crossing after release.

Decomposition:
- Package grid_pkg holds:
  - default geometry constants (X0, Y0, CELL, COLS, ROWS)
  - mode encodings GRID_OFF, GRID_DOTS, GRID_LINES, GRID_BORDER
- Sub-module grid_axis_tracker, parameters ORIGIN, CELL, COUNT, POS_W:
  - inputs: pos, advance
  - outputs: act, idx, sub, err
- Instantiated twice:
  - H: advance=1.
  - V: advance on vcount change.

Test Plan:
- Mode 1, full frame with defaults. Required response:
  - pixel_grid=8'hFF exactly at hcount in {104,130,...,468} x vcount in {17,43,...,589}.
  - 15x23=345 hits per frame.
  - Each hit appears 2 cycles after the matching hcount.
- Mode 2, line vcount=30, hcount=104..468:
  - 8'hFF at the 15 vertical-line pixels, 0 elsewhere.
  - Line vcount=43: 365 consecutive 8'hFF pixels.
- Mode 3, vcount=43:
  - Only hcount 104 and 468 are lit.
  - On vcount=17, all 365 pixels lit.
- Cell outputs at hcount=157, vcount=70 → cell_col=2, cell_x=1, cell_row=2, cell_y=1, in_field=1. At hcount=469 → in_field=0 and all cell outputs 0.
- grid_mode changes 1→2 at vcount=200:
  - Output stays dots until the frame end.
  - Lines appear from the next frame.
- Desync and reset:
  - hcount jumps 200→300 mid-line: trk_err=1, no grid pixels until the next line. trk_err clears at the next frame start.
  - rst_n pulsed low mid-line: all outputs 0 within the same cycle.
